// File: rtl/uart_pkg.sv
// Shared UART definitions used by the echo transmitter and the receiver.
package uart_pkg;

  // 8N1 frame constants
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Width of the per-bit clock counter; holds BPS_CNT-1 for the default clock/baud pair
  localparam int CNT_W = 16;

  // Transmit state encoding
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Clocks per serial bit (integer division, truncating)
  function automatic int bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_echo_send_if.sv
// Byte stream from the UART receiver: a single-cycle valid strobe with its data byte.
interface uart_echo_send_if;
  logic       in_valid;
  logic [7:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/uart_echo_send_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read and a separate occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  // Level never exceeds DEPTH, so its top bit alone means full
  assign full    = level_q[AW];
  assign empty   = (level_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Next pointer and level values; pointers wrap modulo DEPTH
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; resetting the pointers and level already empties it.
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_echo_send.sv
// Echo transmitter: buffers bytes from the UART receiver and sends each one back as 8N1.
// Frames are sent back to back when more bytes are waiting at the end of a stop bit.
module uart_echo_send
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200,
  parameter int FIFO_AW  = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  uart_echo_send_if.slave    in_if,
  output logic               uart_txd,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
);

  localparam int               BPS_CNT      = bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(BPS_CNT - 1);
  localparam logic [2:0]       BIT_IDX_LAST = 3'(DATA_BITS - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             overflow_q, overflow_d;

  logic             push, pop, bit_end;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [FIFO_AW:0] fifo_lvl;

  // A byte arriving while full is kept only if the transmitter frees a slot in the same cycle
  assign push    = in_if.in_valid && (!fifo_full || pop);
  assign bit_end = (cnt_q == BIT_LAST);

  sync_fifo #(
    .DW (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (push),
    .din   (in_if.in_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_lvl)
  );

  // Transmit FSM next state; the line level is computed from the next state so uart_txd is a flop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == BIT_IDX_LAST) state_d = STOP;
          else                       bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = START_BIT;
      DATA:    txd_d = shift_d[bit_d];
      default: txd_d = STOP_BIT;
    endcase
  end

  // Sticky drop flag: set when a byte arrives while full and nothing leaves
  always_comb begin
    overflow_d = overflow_q | (in_if.in_valid && fifo_full && !pop);
  end

  // State, counters, shift register and line registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= STOP_BIT;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
  end

  assign uart_txd   = txd_q;
  assign tx_busy    = (state_q != IDLE);
  assign fifo_level = fifo_lvl;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_echo_send.sv
// Self-checking bench for uart_echo_send at 10 clocks per bit.
// A frame-level model predicts the line every cycle; a serial decoder recovers the sent bytes.
module tb_uart_echo_send;

  localparam int BPS   = 10;
  localparam int FRAME = 10 * BPS;
  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic       uart_txd;
  logic       tx_busy;
  logic [4:0] fifo_level;
  logic       overflow;

  uart_echo_send_if bif ();

  uart_echo_send #(
    .CLK_FREQ (1000000),
    .UART_BPS (100000),
    .FIFO_AW  (4)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .in_if      (bif),
    .uart_txd   (uart_txd),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a byte queue plus the position inside the frame currently on the line
  logic [7:0] m_q [$];
  bit         m_busy;
  int         m_p;
  logic [7:0] m_cur;
  bit         m_ovf;
  bit         m_pop;
  logic [7:0] m_popped;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_busy = 1'b0;
      m_p    = 0;
      m_ovf  = 1'b0;
    end else begin
      m_pop = (m_q.size() > 0) && (!m_busy || m_p == FRAME - 1);
      if (m_pop) m_popped = m_q.pop_front();
      if (bif.in_valid) begin
        if (m_q.size() < DEPTH) m_q.push_back(bif.in_data);
        else                    m_ovf = 1'b1;
      end
      if (m_busy) begin
        if (m_p == FRAME - 1) begin
          if (m_pop) begin m_cur = m_popped; m_p = 0; end
          else         m_busy = 1'b0;
        end else begin
          m_p++;
        end
      end else if (m_pop) begin
        m_busy = 1'b1;
        m_p    = 0;
        m_cur  = m_popped;
      end
    end
  end

  function automatic logic model_txd();
    if (!m_busy)            return 1'b1;
    if (m_p < BPS)          return 1'b0;
    if (m_p < 9 * BPS)      return m_cur[(m_p - BPS) / BPS];
    return 1'b1;
  endfunction

  // Monitors and serial decoder state
  int         busy_cyc, busy_falls, low_cyc, max_level;
  bit         prev_busy;
  bit         dec_act;
  int         dec_pos;
  logic [7:0] dec_byte;
  logic [7:0] rx_q [$];

  // Per-cycle compare against the model, plus line monitors and decoder
  always @(negedge clk) begin
    if (!rst_n) begin
      dec_act   = 1'b0;
      prev_busy = 1'b0;
    end else begin
      check("txd",   32'(uart_txd),   32'(model_txd()));
      check("busy",  32'(tx_busy),    32'(m_busy));
      check("level", 32'(fifo_level), 32'(m_q.size()));
      check("ovf",   32'(overflow),   32'(m_ovf));

      if (tx_busy) busy_cyc++;
      if (prev_busy && !tx_busy) busy_falls++;
      prev_busy = tx_busy;
      if (!uart_txd) low_cyc++;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);

      if (dec_act) begin
        dec_pos++;
        if (dec_pos >= 15 && dec_pos <= 85 && (dec_pos - 15) % 10 == 0)
          dec_byte[(dec_pos - 15) / 10] = uart_txd;
        if (dec_pos == 95) begin
          check("stop_bit", 32'(uart_txd), 32'd1);
          rx_q.push_back(dec_byte);
          dec_act = 1'b0;
        end
      end else if (!uart_txd) begin
        dec_act = 1'b1;
        dec_pos = 0;
      end
    end
  end

  logic [7:0] stim [$];

  task automatic clear_mon();
    busy_cyc   = 0;
    busy_falls = 0;
    low_cyc    = 0;
    max_level  = 0;
    rx_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 clear_mon();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives stim[] on consecutive cycles; returns at the negedge after the last byte
  task automatic send_stim();
    foreach (stim[i]) begin
      @(negedge clk);
      bif.in_valid = 1'b1;
      bif.in_data  = stim[i];
    end
    @(negedge clk);
    bif.in_valid = 1'b0;
    bif.in_data  = 8'hxx;
  endtask

  initial begin
    rst_n        = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    clear_mon();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_txd",   32'(uart_txd),   32'd1);
    check("rst_busy",  32'(tx_busy),    32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf",   32'(overflow),   32'd0);

    // Idle line
    repeat (500) @(negedge clk);
    check("idle_low_cyc",  32'(low_cyc),     32'd0);
    check("idle_busy_cyc", 32'(busy_cyc),    32'd0);
    check("idle_frames",   32'(rx_q.size()), 32'd0);

    // Single byte: line low from t+2, 100 busy cycles, bits recovered as A5
    do_reset();
    stim = '{8'hA5};
    send_stim();
    check("single_t1_txd", 32'(uart_txd), 32'd1);
    @(negedge clk);
    check("single_t2_txd", 32'(uart_txd), 32'd0);
    repeat (130) @(negedge clk);
    check("single_busy_cyc", 32'(busy_cyc),    32'd100);
    check("single_frames",   32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("single_byte", 32'(rx_q[0]), 32'hA5);

    // Back to back: three contiguous frames, one busy interval of 300 clocks
    do_reset();
    stim = '{8'h00, 8'hFF, 8'h55};
    send_stim();
    repeat (330) @(negedge clk);
    check("b2b_busy_cyc",   32'(busy_cyc),    32'd300);
    check("b2b_busy_falls", 32'(busy_falls),  32'd1);
    check("b2b_max_level",  32'(max_level),   32'd2);
    check("b2b_frames",     32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      check("b2b_byte0", 32'(rx_q[0]), 32'h00);
      check("b2b_byte1", 32'(rx_q[1]), 32'hFF);
      check("b2b_byte2", 32'(rx_q[2]), 32'h55);
    end

    // Overflow: 0x00..0x13 back to back, 0x11..0x13 dropped
    do_reset();
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(8'(i));
    send_stim();
    check("ovf_flag",      32'(overflow),  32'd1);
    check("ovf_max_level", 32'(max_level), 32'd16);
    repeat (17 * FRAME + 30) @(negedge clk);
    check("ovf_frames", 32'(rx_q.size()), 32'd17);
    if (rx_q.size() == 17)
      for (int i = 0; i < 17; i++) check("ovf_frame_byte", 32'(rx_q[i]), 32'(i));

    // Full with concurrent pop: 0x20 in flight, 0x21..0x30 buffered, 0x77 on the stop-end cycle
    do_reset();
    stim.delete();
    for (int i = 0; i < 17; i++) stim.push_back(8'(8'h20 + i));
    send_stim();
    check("full_level", 32'(fifo_level), 32'd16);
    repeat (84) @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_data  = 8'h77;
    @(negedge clk);
    bif.in_valid = 1'b0;
    check("full_pop_level", 32'(fifo_level), 32'd16);
    check("full_pop_ovf",   32'(overflow),   32'd0);
    repeat (17 * FRAME + 50) @(negedge clk);
    check("full_frames", 32'(rx_q.size()), 32'd18);
    if (rx_q.size() == 18) begin
      check("full_first", 32'(rx_q[0]),  32'h20);
      check("full_last",  32'(rx_q[17]), 32'h77);
    end

    // Reset during DATA bit 3 of 0xA5 (bit 3 is 0)
    do_reset();
    stim = '{8'hA5, 8'h5A};
    send_stim();
    repeat (45) @(negedge clk);
    check("pre_rst_txd",  32'(uart_txd), 32'd0);
    check("pre_rst_busy", 32'(tx_busy),  32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_txd",   32'(uart_txd),   32'd1);
    check("mid_rst_busy",  32'(tx_busy),    32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_ovf",   32'(overflow),   32'd0);
    clear_mon();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    check("post_rst_low_cyc", 32'(low_cyc),     32'd0);
    check("post_rst_frames",  32'(rx_q.size()), 32'd0);
    stim = '{8'h3C};
    send_stim();
    repeat (110) @(negedge clk);
    check("post_rst_new_frames", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1) check("post_rst_new_byte", 32'(rx_q[0]), 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
